// File: rtl/lab7_soc_pio_ctrl.sv
// Avalon-MM PIO slave: WIDTH-bit output register with atomic set/clear and timed pulses,
// synchronised inputs with edge capture and a maskable level interrupt.
module lab7_soc_pio_ctrl #(
    parameter int               WIDTH        = 8,
    parameter int               EDGE_TYPE    = 0,
    parameter int               PULSE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [2:0] {
        A_DATA  = 3'd0,
        A_INPUT = 3'd1,
        A_MASK  = 3'd2,
        A_EDGE  = 3'd3,
        A_SET   = 3'd4,
        A_CLEAR = 3'd5,
        A_PULSE = 3'd6,
        A_RSVD  = 3'd7
    } addr_e;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_pulse_bits;
    logic [CW-1:0]    r_pulse_cnt;
    logic [WIDTH-1:0] r_s1, r_s2, r_s3;

    addr_e            w_addr;
    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd;
    logic             w_unused_wd;

    assign w_addr      = addr_e'(address);
    assign w_wr        = chipselect && !write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;
    assign w_clr       = (w_wr && w_addr == A_EDGE) ? w_wd : '0;

    always_comb begin
        if (EDGE_TYPE == 0)      w_edge = r_s2 & ~r_s3;
        else if (EDGE_TYPE == 1) w_edge = ~r_s2 & r_s3;
        else                     w_edge = r_s2 ^ r_s3;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_edge_cap <= '0;
        end else begin
            r_s1       <= in_port;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            // OR-ing the new edge last lets a capture win over a same-cycle clear.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= RESET_VALUE;
            r_irq_mask <= '0;
        end else if (w_wr) begin
            case (w_addr)
                A_DATA:  r_data_out <= w_wd;
                A_MASK:  r_irq_mask <= w_wd;
                A_SET:   r_data_out <= r_data_out | w_wd;
                A_CLEAR: r_data_out <= r_data_out & ~w_wd;
                default: ;
            endcase
        end
    end

    // A non-zero PULSE write restarts the count; the count reaching 1 retires all pulse bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse_bits <= '0;
            r_pulse_cnt  <= '0;
        end else if (w_wr && w_addr == A_PULSE && w_wd != '0) begin
            r_pulse_bits <= r_pulse_bits | w_wd;
            r_pulse_cnt  <= CW'(PULSE_CYCLES);
        end else if (r_pulse_cnt == CW'(1)) begin
            r_pulse_bits <= '0;
            r_pulse_cnt  <= '0;
        end else if (r_pulse_cnt != '0) begin
            r_pulse_cnt  <= r_pulse_cnt - CW'(1);
        end
    end

    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_rd = '0;
        case (w_addr)
            A_DATA, A_SET, A_CLEAR: w_rd[WIDTH-1:0] = r_data_out;
            A_INPUT:                w_rd[WIDTH-1:0] = r_s2;
            A_MASK:                 w_rd[WIDTH-1:0] = r_irq_mask;
            A_EDGE:                 w_rd[WIDTH-1:0] = r_edge_cap;
            A_PULSE:                w_rd[WIDTH-1:0] = r_pulse_bits;
            default:                w_rd = '0;
        endcase
    end

    assign readdata = w_rd;
    assign out_port = r_data_out | r_pulse_bits;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_lab7_soc_pio_ctrl.sv
// Self-checking bench for lab7_soc_pio_ctrl: directed scenarios plus random bus/input traffic
// compared against a cycle-counting reference model.
module tb_lab7_soc_pio_ctrl;

    localparam int         W  = 8;
    localparam int         PC = 4;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic         irq;

    lab7_soc_pio_ctrl #(
        .WIDTH(W), .EDGE_TYPE(0), .PULSE_CYCLES(PC), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: registers as plain values, pulse as an expiry edge number,
    // input synchroniser as a history of sampled in_port values.
    logic [W-1:0] m_data, m_mask, m_edge, m_pbits;
    int           m_pend;
    int           n_edge;
    logic [W-1:0] hist[$];
    logic [W-1:0] cur_in;

    function automatic void model_reset();
        m_data  = RV;
        m_mask  = '0;
        m_edge  = '0;
        m_pbits = '0;
        m_pend  = 0;
        n_edge  = 0;
        hist    = '{8'h00, 8'h00, 8'h00};
    endfunction

    function automatic void model_edge(input logic wr, input logic [2:0] a,
                                       input logic [31:0] wdf, input logic [W-1:0] inp);
        logic [W-1:0] synced, older, wd;
        synced = hist[1];
        older  = hist[0];
        wd     = wdf[W-1:0];
        m_edge = (m_edge & ~((wr && a == 3'd3) ? wd : 8'h00)) | (synced & ~older);
        if (wr) begin
            if (a == 3'd0) m_data = wd;
            if (a == 3'd2) m_mask = wd;
            if (a == 3'd4) m_data = m_data | wd;
            if (a == 3'd5) m_data = m_data & ~wd;
        end
        n_edge++;
        if (wr && a == 3'd6 && wd != 0) begin
            m_pbits = m_pbits | wd;
            m_pend  = n_edge + PC;
        end else if (m_pbits != 0 && n_edge >= m_pend) begin
            m_pbits = '0;
        end
        hist.push_back(inp);
        void'(hist.pop_front());
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0, 3'd4, 3'd5: return {24'h0, m_data};
            3'd1:             return {24'h0, hist[1]};
            3'd2:             return {24'h0, m_mask};
            3'd3:             return {24'h0, m_edge};
            3'd6:             return {24'h0, m_pbits};
            default:          return 32'h0;
        endcase
    endfunction

    // One bus cycle, entered and left at the falling edge.
    task automatic cyc(input string tag, input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        in_port    = cur_in;
        #1;
        check({tag, "/rd"}, readdata, exp_rd(a));
        @(posedge clk);
        model_edge(cs && !wn, a, wd, cur_in);
        #1;
        check({tag, "/out"}, {24'h0, out_port}, {24'h0, m_data | m_pbits});
        check({tag, "/irq"}, {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
        @(negedge clk);
    endtask

    task automatic wr(input string tag, input logic [2:0] a, input logic [31:0] wd);
        cyc(tag, 1'b1, 1'b0, a, wd);
    endtask

    task automatic idle(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) cyc(tag, 1'b1, 1'b1, 3'd7, 32'h0);
    endtask

    task automatic peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0;
        writedata = '0; cur_in = '0; in_port = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst/out", {24'h0, out_port}, 32'hA5);
        check("rst/irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        peek("rst/rd2", 3'd2, 32'h0);
        peek("rst/rd3", 3'd3, 32'h0);
        peek("rst/rd6", 3'd6, 32'h0);
        peek("rst/rd7", 3'd7, 32'h0);

        wr("data", 3'd0, 32'hFFFF_FF0F);
        check("data/0F", {24'h0, out_port}, 32'h0F);
        wr("set", 3'd4, 32'h0000_00F0);
        check("set/FF", {24'h0, out_port}, 32'hFF);
        wr("clr", 3'd5, 32'h0000_0081);
        check("clr/7E", {24'h0, out_port}, 32'h7E);

        wr("mask", 3'd2, 32'h04);
        cur_in = 8'h04;
        idle("sync", 2);
        peek("edge/2nd", 3'd3, 32'h00);
        idle("sync", 1);
        peek("edge/3rd", 3'd3, 32'h04);
        check("edge/irq", {31'h0, irq}, 32'h1);
        wr("w1c", 3'd3, 32'h04);
        check("w1c/irq", {31'h0, irq}, 32'h0);

        wr("p/d0", 3'd0, 32'h0);
        wr("pulse", 3'd6, 32'h01);
        for (int i = 0; i < 3; i++) begin
            check("pulse/on", {24'h0, out_port}, 32'h01);
            idle("pulse", 1);
        end
        check("pulse/last", {24'h0, out_port}, 32'h01);
        idle("pulse", 1);
        check("pulse/off", {24'h0, out_port}, 32'h00);
        wr("pulse2", 3'd6, 32'h01);
        idle("pulse2", 1);
        wr("pulse2/re", 3'd6, 32'h02);
        for (int i = 0; i < 3; i++) begin
            check("pulse2/on", {24'h0, out_port}, 32'h03);
            idle("pulse2", 1);
        end
        check("pulse2/last", {24'h0, out_port}, 32'h03);
        idle("pulse2", 1);
        check("pulse2/off", {24'h0, out_port}, 32'h00);
        wr("pulse0", 3'd6, 32'h0);
        check("pulse0/none", {24'h0, out_port}, 32'h00);

        wr("race/clrall", 3'd3, 32'hFF);
        cur_in = 8'h06;
        idle("race/up", 3);
        cur_in = 8'h04;
        idle("race/down", 3);
        peek("race/pre", 3'd3, 32'h02);
        cur_in = 8'h06;
        idle("race/up2", 2);
        wr("race/w1c", 3'd3, 32'h02);
        peek("race/kept", 3'd3, 32'h02);
        wr("race/w1c2", 3'd3, 32'h02);
        peek("race/cleared", 3'd3, 32'h00);

        in_port = 8'h05;
        #2;
        in_port = 8'h04;
        cur_in  = 8'h04;
        idle("glitch", 4);
        peek("glitch/none", 3'd3, 32'h00);
        cur_in = 8'h05;
        idle("one", 1);
        cur_in = 8'h04;
        idle("one", 3);
        peek("one/cap", 3'd3, 32'h01);
        wr("one/w1c", 3'd3, 32'h01);
        idle("one", 4);
        peek("one/single", 3'd3, 32'h00);

        wr("mr/mask", 3'd2, 32'hFF);
        cur_in = 8'h0C;
        idle("mr/sync", 3);
        check("mr/irq1", {31'h0, irq}, 32'h1);
        wr("mr/pulse", 3'd6, 32'h10);
        #2;
        reset = 1'b1;
        #1;
        check("mr/out", {24'h0, out_port}, 32'hA5);
        check("mr/irq0", {31'h0, irq}, 32'h0);
        peek("mr/rd6", 3'd6, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wr("mr/first", 3'd0, 32'h3C);
        check("mr/first3C", {24'h0, out_port}, 32'h3C);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) wd = 32'h0;
            if ($urandom_range(0, 4) == 0)
                cur_in = cur_in ^ W'(1 << $urandom_range(0, W - 1));
            cyc("rand", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
